vga_draw_scheduler: RTL
=======================

// Module: vga_draw_scheduler
// PURPOSE
//  Owns the VGA adapter pixel port (VGA_X/VGA_Y/VGA_COLOR/plot) for the board top level.
//  Two requesters share it: a full-screen clear engine and a filled-box draw engine
//  (e.g. MNIST digit cells, result bars).
//  Round-robin arbitration; each granted job is rastered one pixel per clock.
//  Box jobs are clipped to the screen.
// PARAMETERS
//  SCREEN_W  160  visible width in pixels (X range 0..SCREEN_W-1)
//  SCREEN_H  120  visible height in pixels (Y range 0..SCREEN_H-1)
//  X_W       8    X coordinate / box width bus width
//  Y_W       7    Y coordinate / box height bus width
//  C_W       3    colour width
// PORTS
//  CLOCK_50   in   1    system clock, all logic on rising edge
//  reset      in   1    asynchronous, active-high reset
//  clr_req    in   1    clear request; held high until clr_ack
//  clr_color  in   C_W  fill colour for clear
//  clr_ack    out  1    1-cycle pulse: clear job accepted, clr_color latched
//  box_req    in   1    box request; held high until box_ack
//  box_x      in   X_W  box top-left X
//  box_y      in   Y_W  box top-left Y
//  box_w      in   X_W  box width in pixels (0 = empty job)
//  box_h      in   Y_W  box height in pixels (0 = empty job)
//  box_color  in   C_W  box fill colour
//  box_ack    out  1    1-cycle pulse: box job accepted, box_* latched
//  busy       out  1    high from the cycle after ack through the DONE cycle
//  done       out  1    1-cycle pulse: current job finished
//  VGA_X      out  X_W  pixel X to VGA adapter (registered)
//  VGA_Y      out  Y_W  pixel Y to VGA adapter (registered)
//  VGA_COLOR  out  C_W  pixel colour to VGA adapter (registered)
//  plot       out  1    write strobe to VGA adapter (registered)
// BEHAVIOUR
//  Reset values:
//  - All outputs are 0.
//  - State = IDLE.
//  - last_grant = BOX, so clear wins the first tie.
//  FSM states: IDLE, CLEAR, BOX, DONE.
//  IDLE:
//  - Arbitration is evaluated every cycle.
//  - Only one requester high: that requester is granted.
//  - Both high: grant the one not equal to last_grant, then update last_grant.
//  - Grant cycle: pulse the matching *_ack, latch its operands, zero the
//    raster counters cx/cy, and go to CLEAR or BOX.
//  - plot = 0 while in IDLE.
//  CLEAR:
//  - One pixel per cycle: VGA_X = cx, VGA_Y = cy, VGA_COLOR = latched colour, plot = 1.
//  - Raster order is X fastest: cx wraps SCREEN_W-1 -> 0 and increments cy.
//  - After pixel (SCREEN_W-1, SCREEN_H-1), go to DONE.
//  - Total: exactly SCREEN_W*SCREEN_H plot cycles (19200 at defaults).
//  BOX:
//  - Pixel coordinate = (box_x + cx, box_y + cy).
//  - Sums are computed one bit wider than X_W / Y_W so they never wrap.
//  - plot = 1 only if both sums are < SCREEN_W / SCREEN_H.
//  - Clipped pixels still take a cycle, with plot = 0.
//  - cx runs 0..w-1, cy runs 0..h-1; after the last pixel, go to DONE.
//  - Latency: box_w*box_h cycles.
//  - box_w == 0 or box_h == 0: go directly IDLE -> DONE with no pixel cycles.
//  DONE:
//  - done = 1 and plot = 0 for exactly one cycle, then IDLE.
//  - busy = 1 in this cycle.
//  Timing:
//  - The first pixel appears on the outputs in the cycle after *_ack.
//  - A new ack can occur at the earliest in the cycle after DONE (IDLE cycle).
//  Requests:
//  - Requests raised while busy are not acked.
//  - They are held by the requester and arbitrated on return to IDLE.
//  - Operand changes after ack have no effect on the running job.
//  - A request dropped before ack is simply not served; no error is flagged.
//  Reset mid-job:
//  - The job is aborted immediately (asynchronously).
//  - plot = 0 and state = IDLE.
//  - No done pulse is produced for the aborted job.
//  Outputs:
//  - VGA_X/VGA_Y/VGA_COLOR hold their last values when plot = 0.
//  - Consumers qualify on plot only.
// TESTING
//  1. Reset, then clr_req=1 with clr_color=3'b000.
//     -> clr_ack pulses 1 cycle; exactly 19200 plot cycles covering (0,0)..(159,119)
//        once each; done pulses once.
//  2. box_req with x=10, y=20, w=4, h=3, colour=3'b101.
//     -> 12 plot cycles; first pixel (10,20), last pixel (13,22), raster order X-fastest;
//        done on the next cycle.
//  3. box x=150, y=110, w=20, h=20.
//     -> 400 pixel cycles, exactly 100 with plot=1, all with X<=159 and Y<=119.
//  4. clr_req and box_req both asserted and held, from reset.
//     -> clear acked first, then box acked in the IDLE cycle after clear's done.
//     Re-raise both -> clear wins again only after box has been served (alternation).
//  5. box_w=0 with box_req.
//     -> box_ack, then done on the next cycle, with zero plot cycles.
//  6. Assert reset mid-clear, e.g. at pixel 500.
//     -> plot=0 and busy=0 immediately; no done pulse.
//     After reset release with clr_req held, the clear restarts at (0,0).

Source files
------------

// File: rtl/vga_draw_scheduler_if.sv
// Pixel-port interface between the clear/box requesters and the draw scheduler.
// The scheduler side (slave) drives the acks, status and the VGA adapter pixel port.
interface vga_draw_scheduler_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
);
    logic           clr_req;
    logic [C_W-1:0] clr_color;
    logic           clr_ack;
    logic           box_req;
    logic [X_W-1:0] box_x;
    logic [Y_W-1:0] box_y;
    logic [X_W-1:0] box_w;
    logic [Y_W-1:0] box_h;
    logic [C_W-1:0] box_color;
    logic           box_ack;
    logic           busy;
    logic           done;
    logic [X_W-1:0] VGA_X;
    logic [Y_W-1:0] VGA_Y;
    logic [C_W-1:0] VGA_COLOR;
    logic           plot;

    modport master (
        output clr_req, clr_color, box_req, box_x, box_y, box_w, box_h, box_color,
        input  clr_ack, box_ack, busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );

    modport slave (
        input  clr_req, clr_color, box_req, box_x, box_y, box_w, box_h, box_color,
        output clr_ack, box_ack, busy, done, VGA_X, VGA_Y, VGA_COLOR, plot
    );
endinterface

// File: rtl/vga_draw_scheduler.sv
// Round-robin owner of the VGA adapter pixel port: rasters full-screen clears and
// clipped filled boxes one pixel per clock, with registered pixel outputs.
module vga_draw_scheduler #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int C_W      = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    vga_draw_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_BOX, S_DONE} state_t;

    localparam logic [X_W-1:0] LAST_X = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(SCREEN_H - 1);

    state_t         r_state, w_nextState;
    logic           r_lastBox;
    logic [X_W-1:0] r_cx, w_nextCx;
    logic [Y_W-1:0] r_cy, w_nextCy;
    logic [C_W-1:0] r_color;
    logic [X_W-1:0] r_boxX, r_boxW;
    logic [Y_W-1:0] r_boxY, r_boxH;
    logic [X_W-1:0] r_vgaX;
    logic [Y_W-1:0] r_vgaY;
    logic [C_W-1:0] r_vgaColor;
    logic           r_plot;

    logic           w_idle, w_grantClr, w_grantBox, w_emit, w_pixPlot;
    logic [X_W-1:0] w_baseX;
    logic [Y_W-1:0] w_baseY;
    logic [C_W-1:0] w_pixColor;
    logic [X_W:0]   w_pixX;
    logic [Y_W:0]   w_pixY;

    // Ties go to whichever requester was not served last; acks are suppressed in reset.
    assign w_idle     = (r_state == S_IDLE) && !reset;
    assign w_grantClr = w_idle && bus.clr_req && (!bus.box_req || r_lastBox);
    assign w_grantBox = w_idle && bus.box_req && (!bus.clr_req || !r_lastBox);

    // Next-state logic also selects the pixel that will be shown in the following cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextCx    = r_cx;
        w_nextCy    = r_cy;
        w_baseX     = r_boxX;
        w_baseY     = r_boxY;
        w_pixColor  = r_color;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grantClr) begin
                    w_nextState = S_CLEAR;
                    w_nextCx    = '0;
                    w_nextCy    = '0;
                    w_baseX     = '0;
                    w_baseY     = '0;
                    w_pixColor  = bus.clr_color;
                    w_emit      = 1'b1;
                end else if (w_grantBox) begin
                    w_nextCx   = '0;
                    w_nextCy   = '0;
                    w_baseX    = bus.box_x;
                    w_baseY    = bus.box_y;
                    w_pixColor = bus.box_color;
                    if (bus.box_w == '0 || bus.box_h == '0) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextState = S_BOX;
                        w_emit      = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                w_baseX = '0;
                w_baseY = '0;
                if (r_cx == LAST_X) begin
                    if (r_cy == LAST_Y) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextCx = '0;
                        w_nextCy = r_cy + 1'b1;
                        w_emit   = 1'b1;
                    end
                end else begin
                    w_nextCx = r_cx + 1'b1;
                    w_emit   = 1'b1;
                end
            end
            S_BOX: begin
                if (r_cx == r_boxW - 1'b1) begin
                    if (r_cy == r_boxH - 1'b1) begin
                        w_nextState = S_DONE;
                    end else begin
                        w_nextCx = '0;
                        w_nextCy = r_cy + 1'b1;
                        w_emit   = 1'b1;
                    end
                end else begin
                    w_nextCx = r_cx + 1'b1;
                    w_emit   = 1'b1;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Sums carry one extra bit so boxes running off the right/bottom edge clip instead of wrapping.
    assign w_pixX    = {1'b0, w_baseX} + {1'b0, w_nextCx};
    assign w_pixY    = {1'b0, w_baseY} + {1'b0, w_nextCy};
    assign w_pixPlot = w_emit && (w_pixX < (X_W+1)'(SCREEN_W)) && (w_pixY < (Y_W+1)'(SCREEN_H));

    // State, job operands and the registered pixel port; coordinates only move on plotted pixels.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lastBox  <= 1'b1;
            r_cx       <= '0;
            r_cy       <= '0;
            r_color    <= '0;
            r_boxX     <= '0;
            r_boxY     <= '0;
            r_boxW     <= '0;
            r_boxH     <= '0;
            r_vgaX     <= '0;
            r_vgaY     <= '0;
            r_vgaColor <= '0;
            r_plot     <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cx    <= w_nextCx;
            r_cy    <= w_nextCy;
            if (w_grantClr) begin
                r_color   <= bus.clr_color;
                r_lastBox <= 1'b0;
            end else if (w_grantBox) begin
                r_color   <= bus.box_color;
                r_boxX    <= bus.box_x;
                r_boxY    <= bus.box_y;
                r_boxW    <= bus.box_w;
                r_boxH    <= bus.box_h;
                r_lastBox <= 1'b1;
            end
            r_plot <= w_pixPlot;
            if (w_pixPlot) begin
                r_vgaX     <= w_pixX[X_W-1:0];
                r_vgaY     <= w_pixY[Y_W-1:0];
                r_vgaColor <= w_pixColor;
            end
        end
    end

    assign bus.clr_ack   = w_grantClr;
    assign bus.box_ack   = w_grantBox;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.VGA_X     = r_vgaX;
    assign bus.VGA_Y     = r_vgaY;
    assign bus.VGA_COLOR = r_vgaColor;
    assign bus.plot      = r_plot;

endmodule
